// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared control struct, controller states and load marker for the ID/EX stage.
package id_ex_stage_pkg;
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic {RUN, BUBBLE} state_t;

    typedef struct packed {
        logic       RegWrite;
        logic       ALUSrc;
        logic       MemWrite;
        logic       Branch;
        logic       Jump;
        logic [1:0] ResultSrc;
        logic [3:0] ALUControl;
    } ex_ctrl_t;

    // Strips every side-effecting bit so the slot can never write state.
    function automatic ex_ctrl_t kill_ctrl(input ex_ctrl_t c);
        kill_ctrl          = c;
        kill_ctrl.RegWrite = 1'b0;
        kill_ctrl.MemWrite = 1'b0;
        kill_ctrl.Branch   = 1'b0;
        kill_ctrl.Jump     = 1'b0;
    endfunction
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use compare between the decode slot and a load sitting in EX.
module hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter logic [1:0] LOAD_RESULTSRC = RESULTSRC_LOAD
) (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic [1:0] ex_ResultSrc,
    input  logic [4:0] ex_rd,
    output logic       load_use
);
    // x0 never carries a dependency, so a zero destination can never match.
    assign load_use = id_valid && ex_valid && (ex_ResultSrc == LOAD_RESULTSRC) &&
                      (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, flush and backpressure handling.
// Optional hazard counters (stall_cnt/flush_cnt) are built when HAZARD_CNT_EN is defined.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int         XLEN           = 32,
    parameter logic [1:0] LOAD_RESULTSRC = RESULTSRC_LOAD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic            id_RegWrite,
    input  logic            id_ALUSrc,
    input  logic            id_MemWrite,
    input  logic            id_Branch,
    input  logic            id_Jump,
    input  logic [1:0]      id_ResultSrc,
    input  logic [3:0]      id_ALUControl,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_pc4,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            ex_flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic            ex_RegWrite,
    output logic            ex_ALUSrc,
    output logic            ex_MemWrite,
    output logic            ex_Branch,
    output logic            ex_Jump,
    output logic [1:0]      ex_ResultSrc,
    output logic [3:0]      ex_ALUControl,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_pc4,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd
`ifdef HAZARD_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);
    localparam int DW = 5 * XLEN + 15;

    state_t   state_q, state_d;
    logic     valid_q, valid_d;
    ex_ctrl_t ctrl_q, ctrl_d, id_ctrl;
    logic [DW-1:0] dp_q, dp_d, id_dp;
    logic     load_use_raw, load_use, bubble, kill;

    assign id_ctrl = {id_RegWrite, id_ALUSrc, id_MemWrite, id_Branch, id_Jump, id_ResultSrc, id_ALUControl};
    assign id_dp   = {id_pc, id_pc4, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd};

    assign ex_valid = valid_q;
    assign {ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_Branch, ex_Jump, ex_ResultSrc, ex_ALUControl} = ctrl_q;
    assign {ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd} = dp_q;

    hazard_detect #(.LOAD_RESULTSRC(LOAD_RESULTSRC)) u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (valid_q),
        .ex_ResultSrc(ctrl_q.ResultSrc),
        .ex_rd       (ex_rd),
        .load_use    (load_use_raw)
    );

    // A bubble already has ex_valid=0; gating on RUN keeps the controller's intent explicit.
    assign load_use = load_use_raw && (state_q == RUN);
    assign id_ready = ex_ready && !load_use && !ex_flush;
    assign bubble   = ex_ready && !ex_flush && load_use;
    assign kill     = ex_flush || bubble;

    always_comb begin
        state_d = bubble ? BUBBLE : RUN;
        valid_d = id_ready ? id_valid : (kill ? 1'b0 : valid_q);
        ctrl_d  = id_ready ? (id_valid ? id_ctrl : kill_ctrl(id_ctrl)) : (kill ? kill_ctrl(ctrl_q) : ctrl_q);
        dp_d    = id_ready ? id_dp : dp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            dp_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            dp_q    <= dp_d;
        end
    end

`ifdef HAZARD_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_q + 32'(bubble);
            flush_q <= flush_q + 32'(ex_flush);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scenario tasks plus a scoreboard that checks each accepted decode slot one cycle later.
// Counter checks are compiled in when HAZARD_CNT_EN is defined.
module tb_id_ex_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid = 1'b0, id_ready;
    logic        id_RegWrite = 1'b0, id_ALUSrc = 1'b0, id_MemWrite = 1'b0, id_Branch = 1'b0, id_Jump = 1'b0;
    logic [1:0]  id_ResultSrc = 2'b00;
    logic [3:0]  id_ALUControl = 4'd0;
    logic [31:0] id_pc = '0, id_pc4 = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        ex_flush = 1'b0, ex_ready = 1'b1, ex_valid;
    logic        ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_Branch, ex_Jump;
    logic [1:0]  ex_ResultSrc;
    logic [3:0]  ex_ALUControl;
    logic [31:0] ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
`ifdef HAZARD_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
    } exp_t;

    exp_t q[$];
    exp_t cur, e;
    bit   adv_flag = 1'b0;
    int   tests = 0, fails = 0;

    id_ex_stage #(.XLEN(32), .LOAD_RESULTSRC(2'b01)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc), .id_MemWrite(id_MemWrite),
        .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ResultSrc(id_ResultSrc),
        .id_ALUControl(id_ALUControl), .id_pc(id_pc), .id_pc4(id_pc4), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_flush(ex_flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_RegWrite(ex_RegWrite), .ex_ALUSrc(ex_ALUSrc), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_ResultSrc(ex_ResultSrc),
        .ex_ALUControl(ex_ALUControl), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd)
`ifdef HAZARD_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: every slot the bench expects to be accepted must show up on ex_* one cycle later.
    always @(posedge clk) begin
        #1;
        if (adv_flag) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty: DUT advanced with no expected entry");
            end else begin
                e = q.pop_front();
                if ({ex_valid, ex_pc, ex_rd1, ex_rd, ex_RegWrite, ex_MemWrite} !== {1'b1, e.pc, e.rd1, e.rd, e.rw, e.mw}) begin
                    fails++;
                    $display("FAIL scoreboard: got v=%0b pc=%h rd1=%h rd=%0d rw=%0b mw=%0b, want v=1 pc=%h rd1=%h rd=%0d rw=%0b mw=%0b",
                             ex_valid, ex_pc, ex_rd1, ex_rd, ex_RegWrite, ex_MemWrite, e.pc, e.rd1, e.rd, e.rw, e.mw);
                end
            end
        end
    end

    task automatic set_instr(input bit ld, input bit rw, input bit mw, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] pc, input logic [31:0] rd1);
        id_valid     = 1'b1;
        id_RegWrite  = rw;
        id_MemWrite  = mw;
        id_ResultSrc = ld ? 2'b01 : 2'b00;
        id_ALUSrc    = ld | mw;
        id_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_pc        = pc;
        id_pc4       = pc + 32'd4;
        id_rd1       = rd1;
        id_rd2       = ~rd1;
        id_imm       = pc ^ 32'h55;
        cur          = '{pc: pc, rd1: rd1, rd: rd, rw: rw, mw: mw};
    endtask

    // push=1 means the bench expects the current decode slot to be accepted at this edge.
    task automatic cycle(input bit push);
        if (push) q.push_back(cur);
        adv_flag = push;
        @(posedge clk);
        #2;
        adv_flag = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if ({ex_valid, ex_RegWrite, ex_MemWrite, ex_pc, ex_rd1, ex_rd} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%0b rw=%0b mw=%0b pc=%h rd1=%h rd=%0d, want all 0",
                     ex_valid, ex_RegWrite, ex_MemWrite, ex_pc, ex_rd1, ex_rd);
        end
`ifdef HAZARD_CNT_EN
        tests++;
        if ({stall_cnt, flush_cnt} !== 64'd0) begin
            fails++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d, want 0 0", stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            set_instr(0, 1, 0, 5'(i + 1), 5'(i + 10), 5'(i + 20), 32'h100 + 32'(i * 4), 32'hA000 + 32'(i));
            #1;
            tests++;
            if (id_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready[%0d]: got %0b want 1", i, id_ready);
            end
            cycle(1);
        end
        id_valid = 1'b0;
        cycle(0);
        tests++;
        if ({ex_valid, ex_RegWrite, ex_MemWrite} !== 3'b000) begin
            fails++;
            $display("FAIL idle_slot: got v/rw/mw=%b want 000", {ex_valid, ex_RegWrite, ex_MemWrite});
        end
    endtask

    task automatic test_load_use;
        set_instr(1, 1, 0, 5'd5, 5'd2, 5'd0, 32'h200, 32'h1111);
        cycle(1);
        set_instr(0, 1, 0, 5'd6, 5'd5, 5'd1, 32'h204, 32'h2222);
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            fails++;
            $display("FAIL loaduse_ready: got %0b want 0", id_ready);
        end
        cycle(0);
        tests++;
        if ({ex_valid, ex_RegWrite, ex_MemWrite} !== 3'b000) begin
            fails++;
            $display("FAIL loaduse_bubble: got v/rw/mw=%b want 000", {ex_valid, ex_RegWrite, ex_MemWrite});
        end
        tests++;
        if (id_ready !== 1'b1) begin
            fails++;
            $display("FAIL after_bubble_ready: got %0b want 1", id_ready);
        end
        cycle(1);
`ifdef HAZARD_CNT_EN
        tests++;
        if (stall_cnt !== 32'd1) begin
            fails++;
            $display("FAIL stall_cnt: got %0d want 1", stall_cnt);
        end
`endif
    endtask

    task automatic test_x0_load;
        set_instr(1, 1, 0, 5'd0, 5'd1, 5'd0, 32'h300, 32'h3333);
        cycle(1);
        set_instr(0, 1, 0, 5'd7, 5'd0, 5'd0, 32'h304, 32'h4444);
        #1;
        tests++;
        if (id_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_no_stall: got id_ready=%0b want 1", id_ready);
        end
        cycle(1);
    endtask

    task automatic test_hold;
        set_instr(0, 1, 0, 5'd8, 5'd1, 5'd2, 32'h400, 32'hDEADBEEF);
        cycle(1);
        set_instr(0, 1, 0, 5'd9, 5'd3, 5'd4, 32'h404, 32'h5555);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (id_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_ready[%0d]: got %0b want 0", i, id_ready);
            end
            cycle(0);
            tests++;
            if ({ex_valid, ex_rd1, ex_rd} !== {1'b1, 32'hDEADBEEF, 5'd8}) begin
                fails++;
                $display("FAIL hold_value[%0d]: got v=%0b rd1=%h rd=%0d want v=1 rd1=deadbeef rd=8", i, ex_valid, ex_rd1, ex_rd);
            end
        end
        ex_ready = 1'b1;
        cycle(1);
    endtask

    task automatic test_flush;
        set_instr(0, 0, 1, 5'd0, 5'd1, 5'd2, 32'h500, 32'h6666);
        cycle(1);
        set_instr(0, 1, 0, 5'd10, 5'd1, 5'd2, 32'h504, 32'h7777);
        ex_ready = 1'b0;
        ex_flush = 1'b1;
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready: got %0b want 0", id_ready);
        end
        cycle(0);
        tests++;
        if ({ex_valid, ex_MemWrite, ex_RegWrite} !== 3'b000) begin
            fails++;
            $display("FAIL flush_clear: got v/mw/rw=%b want 000", {ex_valid, ex_MemWrite, ex_RegWrite});
        end
`ifdef HAZARD_CNT_EN
        tests++;
        if (flush_cnt !== 32'd1) begin
            fails++;
            $display("FAIL flush_cnt: got %0d want 1", flush_cnt);
        end
`endif
        ex_flush = 1'b0;
        ex_ready = 1'b1;
        cycle(1);
    endtask

    task automatic test_reset_mid_stall;
        set_instr(1, 1, 0, 5'd7, 5'd0, 5'd0, 32'h600, 32'h8888);
        cycle(1);
        set_instr(0, 1, 0, 5'd11, 5'd7, 5'd3, 32'h604, 32'h9999);
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            fails++;
            $display("FAIL midstall_ready: got %0b want 0", id_ready);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ex_valid, ex_RegWrite, ex_rd, ex_pc} !== '0) begin
            fails++;
            $display("FAIL async_reset: got v=%0b rw=%0b rd=%0d pc=%h want all 0", ex_valid, ex_RegWrite, ex_rd, ex_pc);
        end
`ifdef HAZARD_CNT_EN
        tests++;
        if ({stall_cnt, flush_cnt} !== 64'd0) begin
            fails++;
            $display("FAIL async_reset_cnt: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
        end
`endif
        id_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0);
        tests++;
        if (ex_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_valid: got %0b want 0", ex_valid);
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_load_use;
        test_x0_load;
        test_hold;
        test_flush;
        test_reset_mid_stall;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
